// File: rtl/image_window_ctrl_pkg.sv
// Shared definitions for the 3x3 image window controller: default geometry,
// line-buffer count and the read FSM state encoding.
package image_window_ctrl_pkg;

    localparam int DEF_IMG_WIDTH = 512;
    localparam int DEF_PIX_W     = 8;
    localparam int NUM_LINES     = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_READ = 1'b1
    } rd_state_t;

endpackage

// File: rtl/line_buffer.sv
// One image line of storage: a synchronous write port and a combinational
// read port that returns three neighbouring pixels starting at i_rd_col.
// Columns past the right edge repeat the last pixel of the line.
module line_buffer
    import image_window_ctrl_pkg::*;
#(
    parameter int IMG_WIDTH = DEF_IMG_WIDTH,
    parameter int PIX_W     = DEF_PIX_W
) (
    input  logic                         i_clk,
    input  logic                         i_wr_en,
    input  logic [$clog2(IMG_WIDTH)-1:0] i_wr_col,
    input  logic [PIX_W-1:0]             i_wr_data,
    input  logic [$clog2(IMG_WIDTH)-1:0] i_rd_col,
    output logic [3*PIX_W-1:0]           o_rd_data
);

    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int SUM_W = COL_W + 1;
    localparam logic [SUM_W-1:0] LAST_SUM = SUM_W'(IMG_WIDTH - 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);

    logic [PIX_W-1:0] mem [IMG_WIDTH];
    logic [SUM_W-1:0] col_sum [3];
    logic [COL_W-1:0] col_idx [3];

    // Store one pixel per enabled cycle; contents are never reset.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            mem[i_wr_col] <= i_wr_data;
        end
    end

    // Fetch columns rd_col..rd_col+2, clamped to the last column; pixel k at k*PIX_W.
    always_comb begin
        o_rd_data = '0;
        for (int k = 0; k < 3; k++) begin
            col_sum[k] = {1'b0, i_rd_col} + SUM_W'(k);
            col_idx[k] = (col_sum[k] > LAST_SUM) ? LAST_COL : col_sum[k][COL_W-1:0];
            o_rd_data[k*PIX_W +: PIX_W] = mem[col_idx[k]];
        end
    end

endmodule

// File: rtl/image_window_ctrl.sv
// 3x3 sliding-window generator. Raster pixels are written round-robin into
// four line buffers; once three full lines are waiting, one line's worth of
// windows (one per column) is emitted back to back, after which the oldest
// line is released and o_intr tells upstream it may send another line.
//
// Streams are valid-only: a beat exists exactly in the cycle its valid is
// high and there is no ready. Upstream paces itself with o_intr; an input
// beat arriving while all four lines hold unread pixels and no column is
// being read that cycle is dropped without disturbing any state.
module image_window_ctrl
    import image_window_ctrl_pkg::*;
#(
    parameter int IMG_WIDTH = DEF_IMG_WIDTH,
    parameter int PIX_W     = DEF_PIX_W
) (
    input  logic                                 i_clk,
    input  logic                                 i_rstn,
    input  logic [PIX_W-1:0]                     i_pixel_data,
    input  logic                                 i_pixel_data_valid,
    output logic [9*PIX_W-1:0]                   o_pixel_data,
    output logic                                 o_pixel_data_valid,
    output logic                                 o_intr,
    output logic                                 o_dbg_state,
    output logic [$clog2(4*IMG_WIDTH+1)-1:0]     o_dbg_fill
);

    localparam int COL_W  = $clog2(IMG_WIDTH);
    localparam int FILL_W = $clog2(4*IMG_WIDTH + 1);
    localparam logic [FILL_W-1:0] FILL_FULL  = FILL_W'(NUM_LINES * IMG_WIDTH);
    localparam logic [FILL_W-1:0] FILL_START = FILL_W'(3 * IMG_WIDTH);
    localparam logic [COL_W-1:0]  COL_LAST   = COL_W'(IMG_WIDTH - 1);

    rd_state_t         state;
    rd_state_t         state_nxt;
    logic [COL_W-1:0]  wr_col;
    logic [COL_W-1:0]  rd_col;
    logic [1:0]        wr_sel;
    logic [1:0]        rd_sel;
    logic [FILL_W-1:0] fill;
    logic              rd_en;
    logic              rd_last;
    logic              wr_en;
    logic [NUM_LINES-1:0] lb_wr_en;
    logic [3*PIX_W-1:0]   lb_rd_data [NUM_LINES];
    logic [9*PIX_W-1:0]   window;

    assign rd_en   = (state == ST_READ);
    assign rd_last = rd_en && (rd_col == COL_LAST);
    // A read in the same cycle frees the slot the incoming pixel needs.
    assign wr_en   = i_pixel_data_valid && ((fill != FILL_FULL) || rd_en);

    assign o_dbg_state = (state == ST_READ);
    assign o_dbg_fill  = fill;

    // Steer the write enable to the line currently being filled.
    always_comb begin
        lb_wr_en = '0;
        if (wr_en) begin
            lb_wr_en[wr_sel] = 1'b1;
        end
    end

    for (genvar b = 0; b < NUM_LINES; b++) begin : g_lb
        line_buffer #(
            .IMG_WIDTH (IMG_WIDTH),
            .PIX_W     (PIX_W)
        ) u_lb (
            .i_clk     (i_clk),
            .i_wr_en   (lb_wr_en[b]),
            .i_wr_col  (wr_col),
            .i_wr_data (i_pixel_data),
            .i_rd_col  (rd_col),
            .o_rd_data (lb_rd_data[b])
        );
    end

    // Stack rows oldest line on top; row r takes line (rd_sel + r) mod 4.
    always_comb begin
        window = '0;
        for (int r = 0; r < 3; r++) begin
            window[r*3*PIX_W +: 3*PIX_W] = lb_rd_data[rd_sel + 2'(r)];
        end
    end

    // Write pointer: advance column per stored pixel, move to next line on wrap.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            wr_col <= '0;
            wr_sel <= '0;
        end else if (wr_en) begin
            if (wr_col == COL_LAST) begin
                wr_col <= '0;
                wr_sel <= wr_sel + 2'd1;
            end else begin
                wr_col <= wr_col + 1'b1;
            end
        end
    end

    // Occupancy: stored-but-unconsumed pixels; a write and a read cancel out.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            fill <= '0;
        end else if (wr_en && !rd_en) begin
            fill <= fill + 1'b1;
        end else if (!wr_en && rd_en) begin
            fill <= fill - 1'b1;
        end
    end

    // Read FSM state register.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Read FSM next state: start once three lines wait, stop after last column.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (fill >= FILL_START) state_nxt = ST_READ;
            ST_READ: if (rd_col == COL_LAST) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Read pointer: sweep columns during READ, release the top line at the end.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            rd_col <= '0;
            rd_sel <= '0;
        end else if (rd_en) begin
            if (rd_last) begin
                rd_col <= '0;
                rd_sel <= rd_sel + 2'd1;
            end else begin
                rd_col <= rd_col + 1'b1;
            end
        end
    end

    // Registered outputs: window one cycle after its read, held while idle.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            o_pixel_data       <= '0;
            o_pixel_data_valid <= 1'b0;
            o_intr             <= 1'b0;
        end else begin
            o_pixel_data_valid <= rd_en;
            o_intr             <= rd_last;
            if (rd_en) begin
                o_pixel_data <= window;
            end
        end
    end

endmodule

// File: tb/tb_image_window_ctrl.sv
// Self-checking bench for image_window_ctrl with an 8-pixel line.
module tb_image_window_ctrl;

    localparam int W    = 8;
    localparam int PW   = 8;
    localparam int FULL = 4 * W;

    logic          i_clk = 1'b0;
    logic          i_rstn = 1'b0;
    logic [PW-1:0] i_pixel_data = '0;
    logic          i_pixel_data_valid = 1'b0;
    logic [9*PW-1:0] o_pixel_data;
    logic          o_pixel_data_valid;
    logic          o_intr;
    logic          o_dbg_state;
    logic [5:0]    o_dbg_fill;

    int n_tests = 0;
    int n_fail  = 0;
    bit sb_en   = 1'b0;

    image_window_ctrl #(
        .IMG_WIDTH (W),
        .PIX_W     (PW)
    ) dut (
        .i_clk              (i_clk),
        .i_rstn             (i_rstn),
        .i_pixel_data       (i_pixel_data),
        .i_pixel_data_valid (i_pixel_data_valid),
        .o_pixel_data       (o_pixel_data),
        .o_pixel_data_valid (o_pixel_data_valid),
        .o_intr             (o_intr),
        .o_dbg_state        (o_dbg_state),
        .o_dbg_fill         (o_dbg_fill)
    );

    // ---------------- clock / reset ----------------
    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    // ---------------- reference model + scoreboard ----------------
    // Accepted pixels are numbered in arrival order; logical line L holds
    // accepted pixels L*W..L*W+W-1, and episode e shows lines e, e+1, e+2.
    logic [9*PW-1:0] exp_q[$];
    logic [PW-1:0]   m_acc[$];
    int              m_fill, m_col, m_ep;
    bit              m_read, m_valid, m_intr;
    logic [9*PW-1:0] m_last;

    function automatic logic [9*PW-1:0] model_window(input int ep, input int col);
        logic [9*PW-1:0] w;
        int cc;
        int idx;
        w = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                cc  = (col + c > W - 1) ? W - 1 : col + c;
                idx = (ep + r) * W + cc;
                if (idx < m_acc.size()) w[(r*3+c)*PW +: PW] = m_acc[idx];
            end
        end
        return w;
    endfunction

    initial begin
        bit rd;
        bit acc;
        int fill_now;
        m_fill = 0; m_col = 0; m_ep = 0;
        m_read = 0; m_valid = 0; m_intr = 0; m_last = '0;
        forever begin
            @(posedge i_clk);
            if (!i_rstn) begin
                m_fill = 0; m_col = 0; m_ep = 0;
                m_read = 0; m_valid = 0; m_intr = 0; m_last = '0;
                m_acc.delete();
                exp_q.delete();
            end else begin
                rd       = m_read;
                fill_now = m_fill;
                acc      = i_pixel_data_valid && ((fill_now != FULL) || rd);
                m_valid  = rd;
                m_intr   = 1'b0;
                if (rd) begin
                    m_last = model_window(m_ep, m_col);
                    exp_q.push_back(m_last);
                end
                if (acc) m_acc.push_back(i_pixel_data);
                m_fill = fill_now + (acc ? 1 : 0) - (rd ? 1 : 0);
                if (rd) begin
                    if (m_col == W - 1) begin
                        m_read = 1'b0;
                        m_col  = 0;
                        m_ep++;
                        m_intr = 1'b1;
                    end else begin
                        m_col++;
                    end
                end else if (fill_now >= 3 * W) begin
                    m_read = 1'b1;
                end
            end
        end
    end

    initial begin
        logic [9*PW-1:0] exp_w;
        forever begin
            @(negedge i_clk);
            if (sb_en) begin
                n_tests++;
                if (o_pixel_data_valid !== m_valid) begin
                    n_fail++;
                    $display("FAIL sb_valid @%0t: got %b want %b", $time, o_pixel_data_valid, m_valid);
                end
                n_tests++;
                if (o_intr !== m_intr) begin
                    n_fail++;
                    $display("FAIL sb_intr @%0t: got %b want %b", $time, o_intr, m_intr);
                end
                n_tests++;
                if (o_dbg_fill !== 6'(m_fill)) begin
                    n_fail++;
                    $display("FAIL sb_fill @%0t: got %0d want %0d", $time, o_dbg_fill, m_fill);
                end
                n_tests++;
                if (o_dbg_state !== m_read) begin
                    n_fail++;
                    $display("FAIL sb_state @%0t: got %b want %b", $time, o_dbg_state, m_read);
                end
                n_tests++;
                if (m_valid) begin
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL sb_queue @%0t: got empty queue want one window", $time);
                    end else begin
                        exp_w = exp_q.pop_front();
                        if (o_pixel_data !== exp_w) begin
                            n_fail++;
                            $display("FAIL sb_window @%0t: got %h want %h", $time, o_pixel_data, exp_w);
                        end
                    end
                end else if (o_pixel_data !== m_last) begin
                    n_fail++;
                    $display("FAIL sb_hold @%0t: got %h want %h", $time, o_pixel_data, m_last);
                end
            end
        end
    end

    // ---------------- helpers / drivers ----------------
    function automatic logic [9*PW-1:0] win(input int p0, input int p1, input int p2,
                                            input int p3, input int p4, input int p5,
                                            input int p6, input int p7, input int p8);
        logic [9*PW-1:0] w;
        w = {8'(p8), 8'(p7), 8'(p6), 8'(p5), 8'(p4), 8'(p3), 8'(p2), 8'(p1), 8'(p0)};
        return w;
    endfunction

    task automatic do_reset();
        i_rstn = 1'b0;
        i_pixel_data_valid = 1'b0;
        repeat (2) @(negedge i_clk);
        i_rstn = 1'b1;
    endtask

    task automatic send_pixels(input int base, input int n);
        for (int i = 0; i < n; i++) begin
            i_pixel_data_valid = 1'b1;
            i_pixel_data = 8'(base + i);
            @(negedge i_clk);
        end
        i_pixel_data_valid = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        i_rstn = 1'b0;
        i_pixel_data_valid = 1'b0;
        repeat (3) @(negedge i_clk);
        sb_en = 1'b1;
        n_tests++;
        if (o_pixel_data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", o_pixel_data_valid); end
        n_tests++;
        if (o_intr !== 1'b0) begin n_fail++; $display("FAIL reset_intr: got %b want 0", o_intr); end
        n_tests++;
        if (o_pixel_data !== '0) begin n_fail++; $display("FAIL reset_data: got %h want 0", o_pixel_data); end
        n_tests++;
        if (o_dbg_fill !== 6'd0) begin n_fail++; $display("FAIL reset_fill: got %0d want 0", o_dbg_fill); end
        n_tests++;
        if (o_dbg_state !== 1'b0) begin n_fail++; $display("FAIL reset_state: got %b want 0", o_dbg_state); end
        i_rstn = 1'b1;
    endtask

    task automatic test_first_episode();
        logic [9*PW-1:0] first_w, last_w;
        int nvalid, nintr, first_t, last_t;
        bit seen;
        do_reset();
        send_pixels(0, 24);
        seen = 0; nvalid = 0; nintr = 0; first_t = -1; last_t = -1;
        first_w = 'x; last_w = 'x;
        for (int t = 0; t < 30; t++) begin
            @(negedge i_clk);
            if (o_pixel_data_valid) begin
                if (!seen) begin seen = 1; first_w = o_pixel_data; first_t = t; end
                last_w = o_pixel_data; last_t = t; nvalid++;
            end
            if (o_intr) nintr++;
        end
        n_tests++;
        if (!seen) begin n_fail++; $display("FAIL first_timeout: got no valid window want one within 30 cycles"); end
        n_tests++;
        if (first_w !== win(0,1,2, 8,9,10, 16,17,18)) begin n_fail++; $display("FAIL first_window: got %h want %h", first_w, win(0,1,2, 8,9,10, 16,17,18)); end
        n_tests++;
        if (last_w !== win(7,7,7, 15,15,15, 23,23,23)) begin n_fail++; $display("FAIL first_last_window: got %h want %h", last_w, win(7,7,7, 15,15,15, 23,23,23)); end
        n_tests++;
        if (nvalid !== 8) begin n_fail++; $display("FAIL first_count: got %0d want 8", nvalid); end
        n_tests++;
        if (last_t - first_t !== 7) begin n_fail++; $display("FAIL first_gapless: got span %0d want 7", last_t - first_t); end
        n_tests++;
        if (nintr !== 1) begin n_fail++; $display("FAIL first_intr: got %0d want 1", nintr); end
    endtask

    task automatic test_back_to_back();
        logic [9*PW-1:0] starts [8];
        int nvalid, nintr, nep;
        bit prev_valid;
        do_reset();
        nvalid = 0; nintr = 0; nep = 0; prev_valid = 0;
        for (int e = 0; e < 8; e++) starts[e] = 'x;
        for (int t = 0; t < 200; t++) begin
            if (o_pixel_data_valid) begin
                nvalid++;
                if (!prev_valid) begin
                    if (nep < 8) starts[nep] = o_pixel_data;
                    nep++;
                end
            end
            prev_valid = o_pixel_data_valid;
            if (o_intr) nintr++;
            if (t < 64) begin i_pixel_data_valid = 1'b1; i_pixel_data = 8'(t); end
            else i_pixel_data_valid = 1'b0;
            @(negedge i_clk);
        end
        i_pixel_data_valid = 1'b0;
        n_tests++;
        if (nep !== 6) begin n_fail++; $display("FAIL b2b_episodes: got %0d want 6", nep); end
        n_tests++;
        if (nintr !== 6) begin n_fail++; $display("FAIL b2b_intr: got %0d want 6", nintr); end
        n_tests++;
        if (nvalid !== 48) begin n_fail++; $display("FAIL b2b_count: got %0d want 48", nvalid); end
        n_tests++;
        if (starts[0] !== win(0,1,2, 8,9,10, 16,17,18)) begin n_fail++; $display("FAIL b2b_ep0: got %h want %h", starts[0], win(0,1,2, 8,9,10, 16,17,18)); end
        n_tests++;
        if (starts[1] !== win(8,9,10, 16,17,18, 24,25,26)) begin n_fail++; $display("FAIL b2b_ep1: got %h want %h", starts[1], win(8,9,10, 16,17,18, 24,25,26)); end
        n_tests++;
        if (starts[2] !== win(16,17,18, 24,25,26, 32,33,34)) begin n_fail++; $display("FAIL b2b_ep2_wrap: got %h want %h", starts[2], win(16,17,18, 24,25,26, 32,33,34)); end
        n_tests++;
        if (starts[5] !== win(40,41,42, 48,49,50, 56,57,58)) begin n_fail++; $display("FAIL b2b_ep5: got %h want %h", starts[5], win(40,41,42, 48,49,50, 56,57,58)); end
    endtask

    task automatic test_overflow();
        logic [9*PW-1:0] starts [12];
        logic [9*PW-1:0] last_w;
        int nintr, nep;
        bit prev_valid;
        do_reset();
        nintr = 0; nep = 0; prev_valid = 0; last_w = 'x;
        for (int e = 0; e < 12; e++) starts[e] = 'x;
        for (int t = 0; t < 160; t++) begin
            if (t == 96) begin
                n_tests++;
                if (o_dbg_fill !== 6'd32) begin n_fail++; $display("FAIL ovf_full_before: got %0d want 32", o_dbg_fill); end
                n_tests++;
                if (o_dbg_state !== 1'b0) begin n_fail++; $display("FAIL ovf_idle: got %b want 0", o_dbg_state); end
            end
            if (t == 97) begin
                n_tests++;
                if (o_dbg_fill !== 6'd32) begin n_fail++; $display("FAIL ovf_drop_fill: got %0d want 32", o_dbg_fill); end
            end
            if (o_pixel_data_valid) begin
                last_w = o_pixel_data;
                if (!prev_valid) begin
                    if (nep < 12) starts[nep] = o_pixel_data;
                    nep++;
                end
            end
            prev_valid = o_pixel_data_valid;
            if (o_intr) nintr++;
            if (t < 100) begin i_pixel_data_valid = 1'b1; i_pixel_data = 8'(t); end
            else i_pixel_data_valid = 1'b0;
            @(negedge i_clk);
        end
        i_pixel_data_valid = 1'b0;
        n_tests++;
        if (nep !== 10) begin n_fail++; $display("FAIL ovf_episodes: got %0d want 10", nep); end
        n_tests++;
        if (nintr !== 10) begin n_fail++; $display("FAIL ovf_intr: got %0d want 10", nintr); end
        n_tests++;
        if (starts[8] !== win(64,65,66, 72,73,74, 80,81,82)) begin n_fail++; $display("FAIL ovf_no_overwrite: got %h want %h", starts[8], win(64,65,66, 72,73,74, 80,81,82)); end
        n_tests++;
        if (last_w !== win(79,79,79, 87,87,87, 95,95,95)) begin n_fail++; $display("FAIL ovf_last: got %h want %h", last_w, win(79,79,79, 87,87,87, 95,95,95)); end
    endtask

    task automatic test_reset_mid_read();
        logic [9*PW-1:0] first_w, last_w;
        int cnt, nvalid, nintr, stray;
        bit hit, seen;
        do_reset();
        send_pixels(0, 24);
        cnt = 0; hit = 0;
        for (int t = 0; t < 40; t++) begin
            @(negedge i_clk);
            if (o_pixel_data_valid) cnt++;
            if (cnt == 4) begin hit = 1; break; end
        end
        n_tests++;
        if (!hit) begin n_fail++; $display("FAIL midrst_timeout: got %0d windows want 4", cnt); end
        i_rstn = 1'b0;
        @(negedge i_clk);
        n_tests++;
        if (o_pixel_data_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b want 0", o_pixel_data_valid); end
        n_tests++;
        if (o_intr !== 1'b0) begin n_fail++; $display("FAIL midrst_intr: got %b want 0", o_intr); end
        i_rstn = 1'b1;
        stray = 0;
        for (int t = 0; t < 15; t++) begin
            @(negedge i_clk);
            if (o_pixel_data_valid || o_intr) stray++;
        end
        n_tests++;
        if (stray !== 0) begin n_fail++; $display("FAIL midrst_quiet: got %0d active cycles want 0", stray); end
        send_pixels(50, 24);
        seen = 0; nvalid = 0; nintr = 0; first_w = 'x; last_w = 'x;
        for (int t = 0; t < 30; t++) begin
            @(negedge i_clk);
            if (o_pixel_data_valid) begin
                if (!seen) begin seen = 1; first_w = o_pixel_data; end
                last_w = o_pixel_data; nvalid++;
            end
            if (o_intr) nintr++;
        end
        n_tests++;
        if (first_w !== win(50,51,52, 58,59,60, 66,67,68)) begin n_fail++; $display("FAIL midrst_restart_first: got %h want %h", first_w, win(50,51,52, 58,59,60, 66,67,68)); end
        n_tests++;
        if (last_w !== win(57,57,57, 65,65,65, 73,73,73)) begin n_fail++; $display("FAIL midrst_restart_last: got %h want %h", last_w, win(57,57,57, 65,65,65, 73,73,73)); end
        n_tests++;
        if (nvalid !== 8) begin n_fail++; $display("FAIL midrst_restart_count: got %0d want 8", nvalid); end
        n_tests++;
        if (nintr !== 1) begin n_fail++; $display("FAIL midrst_restart_intr: got %0d want 1", nintr); end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_first_episode();
        test_back_to_back();
        test_overflow();
        test_reset_mid_read();
        repeat (2) @(negedge i_clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
